image_port_arbiter: RTL and testbench
=====================================

// Module: image_port_arbiter
// PURPOSE
//  Shares one read port of the 64x64 binary image BRAM among NREQ requesters
//  (start-point scanner, contour tracer, area counter, host readback).
//  Round-robin arbitration with optional per-requester burst lock.
//  Returns each 64-bit row to its requester, tagged with a one-hot valid,
//  READ_LAT cycles after grant.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  ADDR_W    6   row address width (64 rows)
//  DATA_W    64  row width, one bit per pixel
//  READ_LAT  1   BRAM read latency in cycles (1..3)
//  MAX_LOCK  8   max consecutive locked grants to one requester (>=1)
// PORTS
//  Clk        in   1              clock
//  reset      in   1              synchronous, active-high
//  req_valid  in   NREQ           request i pending
//  req_lock   in   NREQ           request i wants to keep priority next cycle
//  req_addr   in   NREQ*ADDR_W    row address; slice i = [i*ADDR_W +: ADDR_W]
//  req_ready  out  NREQ           one-hot grant; transfer = req_valid&req_ready
//  rsp_valid  out  NREQ           one-hot: rsp_data belongs to requester i
//  rsp_data   out  DATA_W         row data (pass-through of mem_data)
//  mem_en     out  1              BRAM read enable
//  mem_addr   out  ADDR_W         BRAM row address
//  mem_data   in   DATA_W         BRAM read data, valid READ_LAT cycles after mem_en
//  busy       out  1              any read in flight or any grant this cycle
// BEHAVIOUR
//  Reset (sync): rr_ptr=0, lock_cnt=0, latency pipe cleared.
//   Outputs: req_ready=0, rsp_valid=0, mem_en=0, mem_addr=0, busy=0.
//  Arbitration, combinational each cycle:
//   - Pick the first i with req_valid[i], searching from rr_ptr upward and
//     wrapping NREQ-1 -> 0.
//   - req_ready = one-hot(i). mem_en=1; mem_addr = req_addr slice i.
//   - No valid requests: req_ready=0, mem_en=0, mem_addr keeps its last value.
//  Pointer update, at the clock edge of a grant to g:
//   - req_lock[g]=1 and lock_cnt < MAX_LOCK-1: rr_ptr<=g, lock_cnt<=lock_cnt+1.
//   - Otherwise: rr_ptr <= (g+1) mod NREQ, lock_cnt <= 0.
//   - lock_cnt reaching MAX_LOCK-1 forces rotation. If g is then the only
//     requester, it is still granted next cycle (normal search wraps back to it).
//   - No grant: rr_ptr and lock_cnt unchanged.
//  Response:
//   - Grant one-hot enters a READ_LAT-deep shift register.
//   - rsp_valid = pipe output; rsp_data = mem_data, unregistered.
//   - Fully pipelined: one grant and one response per cycle, back-to-back.
//   - No backpressure on responses: requester must accept rsp_valid when it arrives.
//  Requester rules:
//   - Hold req_addr stable while req_valid & !req_ready.
//   - Deasserting req_valid without a grant is allowed (no transfer).
//  Responses return in grant order. A grant whose req_valid drops in the same
//   cycle still issued the read and still gets its response.
//  Reset mid-operation: all in-flight reads are discarded; no rsp_valid
//   pulses after reset is sampled.
//  busy = |req_ready | (|pipe contents).
// TESTING
//  T1 Reset, then all 4 req_valid with addr 0,1,2,3 held -> grants 0,1,2,3 on
//     consecutive cycles; rsp_valid 0001,0010,0100,1000 one cycle later;
//     rsp_data = image rows 0..3.
//  T2 Req 2 alone, addr 0..9 for 10 cycles -> req_ready[2] high 10 cycles;
//     10 back-to-back responses, rows 0..9.
//  T3 Wrap: grant to 2 (rr_ptr=3), then req 0 and 3 valid -> grant 3, then 0.
//  T4 Lock: req0 valid+lock continuously, req1 valid, MAX_LOCK=8 -> 8 grants
//     to 0, then 1 grant to 1, then 0 again.
//  T5 READ_LAT=2: grant at cycle t, reset at t+1 -> no rsp_valid at t+2;
//     all outputs 0.
//  T6 READ_LAT=3, random valid/lock/addr for 2000 cycles, scoreboard checks:
//     no starvation beyond NREQ*MAX_LOCK cycles; every grant gets exactly one
//     correct response.

Source files
------------

// File: rtl/image_port_arbiter.sv
// Round-robin arbiter sharing one image BRAM read port among NREQ requesters.
// Supports per-requester burst lock and returns each row tagged with a one-hot valid.
module image_port_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   busy
);

    localparam int unsigned PtrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned LockW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [NREQ-1:0]   pipe_q [READ_LAT];
    logic [NREQ-1:0]   pipe_d [READ_LAT];

    logic              gnt_found;
    logic              gnt_valid;
    logic [PtrW-1:0]   gnt_idx;
    logic [PtrW-1:0]   cand;
    logic [NREQ-1:0]   gnt_oh;
    logic [ADDR_W-1:0] gnt_addr;
    logic              pipe_any;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = PtrW'((32'(rr_ptr_q) + off) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_valid = gnt_found & ~reset;
        gnt_oh    = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;
        gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    end

    // Lock holds priority on the granted requester until MAX_LOCK grants in a row.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        mem_addr_d = mem_addr_q;
        if (gnt_valid) begin
            mem_addr_d = gnt_addr;
            if (req_lock[gnt_idx] && (32'(lock_cnt_q) < MAX_LOCK - 1)) begin
                rr_ptr_d   = gnt_idx;
                lock_cnt_d = lock_cnt_q + LockW'(1);
            end else begin
                rr_ptr_d   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PtrW'(1);
                lock_cnt_d = '0;
            end
        end
    end

    always_comb begin
        pipe_d[0] = gnt_oh;
        for (int unsigned k = 1; k < READ_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            mem_addr_q <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            mem_addr_q <= mem_addr_d;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int unsigned k = 0; k < READ_LAT; k++) begin
            pipe_any = pipe_any | (|pipe_q[k]);
        end
    end

    // Outputs are forced quiet while reset is asserted so no stale response escapes.
    always_comb begin
        req_ready = gnt_oh;
        mem_en    = gnt_valid;
        mem_addr  = reset ? '0 : mem_addr_d;
        rsp_valid = reset ? '0 : pipe_q[READ_LAT-1];
        rsp_data  = mem_data;
        busy      = ~reset & ((|gnt_oh) | pipe_any);
    end

endmodule

// File: tb/tb_image_port_arbiter.sv
// Bench for image_port_arbiter: three instances (READ_LAT 1/2/3) share stimulus and are
// compared every cycle against a cycle-indexed reference model of arbitration and responses.
module tb_image_port_arbiter;

    localparam int NR   = 4;
    localparam int MAXL = 8;

    logic        Clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [23:0] req_addr;

    logic [3:0]  req_ready [3];
    logic [3:0]  rsp_valid [3];
    logic [63:0] rsp_data  [3];
    logic [63:0] mem_data  [3];
    logic        mem_en    [3];
    logic [5:0]  mem_addr  [3];
    logic        busy      [3];

    image_port_arbiter #(.NREQ(4), .ADDR_W(6), .DATA_W(64), .READ_LAT(1), .MAX_LOCK(8)) u_dut_l1 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
        .mem_data(mem_data[0]), .busy(busy[0])
    );
    image_port_arbiter #(.NREQ(4), .ADDR_W(6), .DATA_W(64), .READ_LAT(2), .MAX_LOCK(8)) u_dut_l2 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
        .mem_data(mem_data[1]), .busy(busy[1])
    );
    image_port_arbiter #(.NREQ(4), .ADDR_W(6), .DATA_W(64), .READ_LAT(3), .MAX_LOCK(8)) u_dut_l3 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]),
        .rsp_data(rsp_data[2]), .mem_en(mem_en[2]), .mem_addr(mem_addr[2]),
        .mem_data(mem_data[2]), .busy(busy[2])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Image memory plus a BRAM model per instance with matching read latency.
    logic [63:0] img [64];
    logic [63:0] bp  [3][3];

    always @(posedge Clk) begin
        for (int u = 0; u < 3; u++) begin
            if (mem_en[u]) bp[u][0] <= img[mem_addr[u]];
            bp[u][1] <= bp[u][0];
            bp[u][2] <= bp[u][1];
        end
    end

    assign mem_data[0] = bp[0][0];
    assign mem_data[1] = bp[1][1];
    assign mem_data[2] = bp[2][2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state.
    int          rr = 0;
    int          lcnt = 0;
    logic [5:0]  last_addr = '0;
    int          last_rst = -100;
    logic [3:0]  gnt_log  [4096];
    logic [5:0]  addr_log [4096];
    logic [3:0]  cur_gnt;
    logic [3:0]  obs_ready;
    logic [3:0]  obs_rsp  [3];
    logic        obs_busy [3];
    int          wait_c   [4];
    int          max_wait [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0] gnt;
        logic [5:0] addr;
        logic [1:0] k;
        logic [3:0] exp_rsp;
        logic       exp_busy;
        logic       found;
        int         lat;
        int         t;
        @(negedge Clk);
        gnt   = '0;
        addr  = last_addr;
        found = 1'b0;
        if (reset) begin
            last_rst = cyc;
            addr     = '0;
        end else begin
            for (int off = 0; off < NR; off++) begin
                k = 2'((rr + off) % NR);
                if (!found && req_valid[k]) begin
                    found = 1'b1;
                    gnt   = 4'b0001 << k;
                    addr  = req_addr[k*6 +: 6];
                    if (req_lock[k] && lcnt < MAXL - 1) begin
                        rr   = int'(k);
                        lcnt = lcnt + 1;
                    end else begin
                        rr   = (int'(k) + 1) % NR;
                        lcnt = 0;
                    end
                end
            end
        end
        gnt_log[cyc]  = gnt;
        addr_log[cyc] = addr;

        for (int u = 0; u < 3; u++) begin
            lat      = u + 1;
            exp_rsp  = '0;
            exp_busy = |gnt;
            if (!reset) begin
                for (int d = lat; d >= 1; d--) begin
                    t = cyc - d;
                    if (t >= 0 && last_rst <= t) begin
                        if (d == lat) exp_rsp = gnt_log[t];
                        if (gnt_log[t] != 4'b0) exp_busy = 1'b1;
                    end
                end
            end
            check("req_ready", 64'(req_ready[u]), 64'(gnt));
            check("mem_en", 64'(mem_en[u]), 64'(|gnt));
            check("mem_addr", 64'(mem_addr[u]), 64'(addr));
            check("rsp_valid", 64'(rsp_valid[u]), 64'(exp_rsp));
            check("busy", 64'(busy[u]), 64'(exp_busy));
            if (exp_rsp != 4'b0) check("rsp_data", rsp_data[u], img[addr_log[cyc-lat]]);
            obs_rsp[u]  = rsp_valid[u];
            obs_busy[u] = busy[u];
        end
        obs_ready = req_ready[0];

        for (int i = 0; i < NR; i++) begin
            if (reset || !req_valid[i] || req_ready[2][i]) wait_c[i] = 0;
            else wait_c[i] = wait_c[i] + 1;
            if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
        end

        if (reset) begin
            rr        = 0;
            lcnt      = 0;
            last_addr = '0;
        end else begin
            last_addr = addr;
        end
        cur_gnt = gnt;
        cyc     = cyc + 1;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        req_addr[i*6 +: 6] = 6'(a);
    endtask

    initial begin
        for (int r = 0; r < 64; r++) img[r] = {$urandom, $urandom};
        for (int i = 0; i < NR; i++) begin
            wait_c[i]   = 0;
            max_wait[i] = 0;
        end
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        step();
        step();
        reset = 1'b0;

        // T1: four simultaneous requests served in order 0..3.
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_addr(i, i);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_order", 64'(obs_ready), 64'(4'b0001 << k));
            req_valid = req_valid & ~cur_gnt;
        end
        step();
        step();

        // T2: lone requester streams ten rows back-to-back.
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            set_addr(2, k);
            step();
            check("t2_ready", 64'(obs_ready), 64'(4'b0100));
        end
        req_valid = '0;
        step();
        step();
        step();

        // T3: pointer wraps from 3 back to 0.
        req_valid = 4'b0100;
        set_addr(2, 5);
        step();
        req_valid = 4'b1001;
        set_addr(0, 11);
        set_addr(3, 12);
        step();
        check("t3_wrap_first", 64'(obs_ready), 64'(4'b1000));
        req_valid = req_valid & ~cur_gnt;
        step();
        check("t3_wrap_second", 64'(obs_ready), 64'(4'b0001));
        req_valid = '0;
        step();
        step();

        // T4: locked burst capped at MAX_LOCK, then rotation.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 4'b0011;
        req_lock  = 4'b0001;
        set_addr(1, 40);
        for (int k = 0; k < 10; k++) begin
            set_addr(0, 20 + k);
            step();
            check("t4_lock", 64'(obs_ready),
                  64'((k < 8) ? 4'b0001 : ((k == 8) ? 4'b0010 : 4'b0001)));
            if (cur_gnt[1]) set_addr(1, 41);
        end
        req_valid = '0;
        req_lock  = '0;
        step();
        step();
        step();
        step();

        // T5: reset right after a grant discards the in-flight read.
        req_valid = 4'b0001;
        set_addr(0, 7);
        step();
        req_valid = '0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t5_rsp_l2", 64'(obs_rsp[1]), 64'(0));
        check("t5_busy_l2", 64'(obs_busy[1]), 64'(0));
        step();
        step();
        step();

        // T6: randomized traffic with occasional resets.
        for (int i = 0; i < NR; i++) max_wait[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i]) begin
                    if (cur_gnt[i]) begin
                        if ($urandom_range(1, 0) == 1) set_addr(i, int'($urandom_range(63, 0)));
                        else req_valid[i] = 1'b0;
                    end else if ($urandom_range(31, 0) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    set_addr(i, int'($urandom_range(63, 0)));
                end
                req_lock[i] = 1'($urandom_range(1, 0));
            end
            reset = ($urandom_range(499, 0) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        for (int k = 0; k < 5; k++) step();
        for (int i = 0; i < NR; i++) begin
            check("no_starve", 64'(max_wait[i] < NR * MAXL), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
